// File: rtl/sata_link_crc_tx.sv
// Transmit-side SATA link CRC stage: forwards FIS payload dwords and appends the CRC-32 dword.
// Optional macro SATA_CRC_CORRUPT_EN adds crc_corrupt to invert the emitted CRC for error-path tests.
module sata_link_crc_tx #(
   parameter int          DATA_BYTE_WIDTH = 4,
   parameter int          MAX_DWORDS      = 2049,
   parameter logic [31:0] CRC_INIT        = 32'h52325032
) (
   input  logic                           clk,
   input  logic                           rst_n,
   input  logic [DATA_BYTE_WIDTH*8-1:0]   in_data,
   input  logic                           in_val,
   input  logic                           in_last,
   output logic                           in_ready,
   output logic [DATA_BYTE_WIDTH*8-1:0]   out_data,
   output logic                           out_val,
   output logic                           out_crc,
   input  logic                           out_ready,
`ifdef SATA_CRC_CORRUPT_EN
   input  logic                           crc_corrupt,
`endif
   output logic                           len_err
);

   localparam logic [31:0] POLY    = 32'h04C11DB7;
   localparam logic [11:0] MAX_CNT = 12'(MAX_DWORDS);
   localparam logic [11:0] CNT_SAT = 12'hFFF;
   localparam logic        ST_DATA = 1'b0;
   localparam logic        ST_CRC  = 1'b1;

   logic        state_reg;
   logic [31:0] crc_reg;
   logic [31:0] crc_next;
   logic [31:0] crc_out;
   logic [11:0] cnt_reg;
   logic        out_free;
   logic        in_xfer;

   // One dword per update, bit 31 first, no reflection.
   function automatic logic [31:0] crc_step(input logic [31:0] c, input logic [31:0] d);
      logic [31:0] r;
      r = c;
      for (int i = 31; i >= 0; i--) begin
         r = (r[31] ^ d[i]) ? ((r << 1) ^ POLY) : (r << 1);
      end
      return r;
   endfunction

   assign out_free = !out_val || out_ready;
   assign in_ready = (state_reg == ST_DATA) && out_free;
   assign in_xfer  = in_val && in_ready;
   assign crc_next = crc_step(crc_reg, in_data);

`ifdef SATA_CRC_CORRUPT_EN
   assign crc_out = crc_reg ^ {32{crc_corrupt}};
`else
   assign crc_out = crc_reg;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg <= ST_DATA;
         crc_reg   <= CRC_INIT;
         cnt_reg   <= '0;
         out_data  <= '0;
         out_val   <= 1'b0;
         out_crc   <= 1'b0;
         len_err   <= 1'b0;
      end else begin
         len_err <= 1'b0;
         if (state_reg == ST_DATA) begin
            if (in_xfer) begin
               out_data <= in_data;
               out_val  <= 1'b1;
               out_crc  <= 1'b0;
               crc_reg  <= crc_next;
               cnt_reg  <= (cnt_reg == CNT_SAT) ? cnt_reg : cnt_reg + 12'd1;
               len_err  <= (cnt_reg == MAX_CNT);
               if (in_last) begin
                  state_reg <= ST_CRC;
               end
            end else if (out_ready) begin
               out_val <= 1'b0;
               out_crc <= 1'b0;
            end
         end else begin
            // CRC slot: waits for the output register, then rearms for the next frame.
            if (out_free) begin
               out_data  <= crc_out;
               out_val   <= 1'b1;
               out_crc   <= 1'b1;
               crc_reg   <= CRC_INIT;
               cnt_reg   <= '0;
               state_reg <= ST_DATA;
            end
         end
      end
   end

endmodule

// File: tb/tb_sata_link_crc_tx.sv
// Self-checking bench for sata_link_crc_tx: cycle table for the basic frame, then randomized
// frames checked against a byte-table CRC model and an expected-output scoreboard.
module tb_sata_link_crc_tx;

   localparam logic [31:0] CRC_INIT = 32'h52325032;
   localparam logic [31:0] POLY     = 32'h04C11DB7;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [31:0] in_data = '0;
   logic        in_val = 1'b0;
   logic        in_last = 1'b0;
   logic        in_ready;
   logic [31:0] out_data;
   logic        out_val;
   logic        out_crc;
   logic        out_ready = 1'b1;
   logic        len_err;
`ifdef SATA_CRC_CORRUPT_EN
   logic        crc_corrupt = 1'b0;
`endif

   sata_link_crc_tx #(.DATA_BYTE_WIDTH(4), .MAX_DWORDS(2049), .CRC_INIT(CRC_INIT)) dut (
      .clk(clk), .rst_n(rst_n),
      .in_data(in_data), .in_val(in_val), .in_last(in_last), .in_ready(in_ready),
      .out_data(out_data), .out_val(out_val), .out_crc(out_crc), .out_ready(out_ready),
`ifdef SATA_CRC_CORRUPT_EN
      .crc_corrupt(crc_corrupt),
`endif
      .len_err(len_err)
   );

   always #5 clk = ~clk;

   typedef struct packed { logic [31:0] d; logic c; } ent_t;
   typedef struct {
      logic val; logic [31:0] data; logic last; logic rdy;
      logic e_val; logic [31:0] e_data; logic e_crc; logic e_rdy;
   } vec_t;

   int          checks = 0;
   int          failures = 0;
   logic [31:0] tbl [256];
   ent_t        exp_q [$];
   logic [31:0] frame_q [$];
   bit          rdy_q [$];
   bit          rdy_rand = 0;
   bit          corrupt_flag = 0;
   logic        drv_val = 0;
   logic [31:0] drv_data = '0;
   logic        drv_last = 0;
   bit          prev_stall = 0;
   logic [31:0] prev_d;
   logic        prev_c;
   int          fcnt = 0;
   bit          frame_done = 1;
   int          lenerr_count = 0;
   int          lenerr_at = 0;
   bit          b2b_seen = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s actual=%h required=%h", name, act, req);
      end
   endtask

   task automatic fail(input string name);
      checks++;
      failures++;
      $display("FAIL %s timeout", name);
   endtask

   // Byte-at-a-time table CRC over a whole frame, MSB byte first.
   function automatic logic [31:0] model_crc(input logic [31:0] dw [$]);
      logic [31:0] c;
      logic [7:0]  b;
      c = CRC_INIT;
      foreach (dw[k]) begin
         for (int s = 3; s >= 0; s--) begin
            b = dw[k][s*8 +: 8];
            c = {c[23:0], 8'h00} ^ tbl[c[31:24] ^ b];
         end
      end
      return c;
   endfunction

   task automatic tick(output bit acc);
      ent_t e;
      @(negedge clk);
      in_val  = drv_val;
      in_data = drv_data;
      in_last = drv_last;
      if (rdy_q.size() != 0) out_ready = rdy_q.pop_front();
      else if (rdy_rand)     out_ready = ($urandom_range(0, 3) != 0);
      else                   out_ready = 1'b1;
      #1;
      if (prev_stall) begin
         chk("hold_val", 32'(out_val), 32'd1);
         chk("hold_data", out_data, prev_d);
         chk("hold_crc", 32'(out_crc), 32'(prev_c));
      end
      if (len_err) begin
         lenerr_count++;
         lenerr_at = fcnt;
      end
      if (out_val && out_ready) begin
         if (exp_q.size() == 0) begin
            fail("unexpected_output");
         end else begin
            e = exp_q.pop_front();
            chk("out_data", out_data, e.d);
            chk("out_crc", 32'(out_crc), 32'(e.c));
         end
      end
      prev_stall = out_val && !out_ready;
      prev_d = out_data;
      prev_c = out_crc;
      acc = in_val && in_ready;
      if (acc) begin
         if (out_val && out_ready && out_crc) b2b_seen = 1;
         if (frame_done) begin fcnt = 0; frame_done = 0; end
         fcnt++;
         exp_q.push_back({in_data, 1'b0});
         frame_q.push_back(in_data);
         if (in_last) begin
            exp_q.push_back({model_crc(frame_q) ^ (corrupt_flag ? 32'hFFFFFFFF : 32'h0), 1'b1});
            frame_q.delete();
            frame_done = 1;
         end
      end
   endtask

   task automatic send_frame(input int n, input bit gaps, input int stop);
      bit acc;
      int waitc;
      for (int idx = 0; idx < stop; idx++) begin
         acc = 0;
         waitc = 0;
         while (!acc) begin
            if (gaps && $urandom_range(0, 3) == 0) begin
               drv_val = 0; drv_last = 1'($urandom); drv_data = $urandom;
            end else begin
               drv_val = 1; drv_last = (idx == n - 1); drv_data = $urandom;
            end
            tick(acc);
            waitc++;
            if (!acc && waitc > 100) begin
               fail("input_accept");
               return;
            end
         end
      end
      drv_val = 0;
   endtask

   task automatic drain();
      bit acc;
      int c = 0;
      drv_val = 0;
      while ((exp_q.size() != 0 || out_val) && c < 200) begin
         drv_last = 1'($urandom);
         drv_data = $urandom;
         tick(acc);
         c++;
      end
      if (c >= 200) fail("drain");
      chk("drain_empty", 32'(exp_q.size()), 32'd0);
   endtask

   vec_t        vt [5];
   logic [31:0] q2 [$];
   logic [31:0] crc_a;

   initial begin
      for (int i = 0; i < 256; i++) begin
         logic [31:0] r;
         r = 32'(i) << 24;
         for (int k = 0; k < 8; k++) r = r[31] ? ((r << 1) ^ POLY) : (r << 1);
         tbl[i] = r;
      end
      q2 = '{32'h00000027, 32'h00EC0000};
      crc_a = model_crc(q2);
      vt[0] = '{1'b1, 32'h00000027, 1'b0, 1'b1, 1'b0, 32'h0,         1'b0, 1'b1};
      vt[1] = '{1'b1, 32'h00EC0000, 1'b1, 1'b1, 1'b1, 32'h00000027, 1'b0, 1'b1};
      vt[2] = '{1'b0, 32'h0,        1'b0, 1'b1, 1'b1, 32'h00EC0000, 1'b0, 1'b0};
      vt[3] = '{1'b0, 32'h0,        1'b0, 1'b1, 1'b1, crc_a,        1'b1, 1'b1};
      vt[4] = '{1'b0, 32'h0,        1'b0, 1'b1, 1'b0, 32'h0,        1'b0, 1'b1};

      repeat (3) @(negedge clk);
      chk("rst_out_data", out_data, 32'h0);
      chk("rst_out_val", 32'(out_val), 32'd0);
      chk("rst_out_crc", 32'(out_crc), 32'd0);
      chk("rst_in_ready", 32'(in_ready), 32'd1);
      chk("rst_len_err", 32'(len_err), 32'd0);
      rst_n = 1'b1;

      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         in_val = vt[i].val; in_data = vt[i].data; in_last = vt[i].last; out_ready = vt[i].rdy;
         #1;
         $display("vec %0d out_val=%0b out_data=%h out_crc=%0b in_ready=%0b", i, out_val, out_data, out_crc, in_ready);
         chk($sformatf("vec%0d_out_val", i), 32'(out_val), 32'(vt[i].e_val));
         chk($sformatf("vec%0d_in_ready", i), 32'(in_ready), 32'(vt[i].e_rdy));
         if (vt[i].e_val) begin
            chk($sformatf("vec%0d_out_data", i), out_data, vt[i].e_data);
            chk($sformatf("vec%0d_out_crc", i), 32'(out_crc), 32'(vt[i].e_crc));
         end
      end
      in_val = 0;

      // Backpressure 1,0,0,1 during a 4-dword frame.
      rdy_q = '{1'b1, 1'b0, 1'b0, 1'b1};
      send_frame(4, 0, 4);
      drain();
      $display("backpressure frame done");

      // Back-to-back 1-dword and 3-dword frames.
      b2b_seen = 0;
      send_frame(1, 0, 1);
      send_frame(3, 0, 3);
      drain();
      chk("b2b_same_cycle", 32'(b2b_seen), 32'd1);
      $display("back-to-back frames done");

      // Random frames, random gaps, random backpressure.
      rdy_rand = 1;
      for (int f = 0; f < 25; f++) begin
         send_frame(int'($urandom_range(1, 8)), 1, 0 + 0);
      end
      for (int f = 0; f < 25; f++) begin
         int n;
         n = int'($urandom_range(1, 8));
         send_frame(n, 1, n);
         $display("random frame %0d len=%0d", f, n);
      end
      rdy_rand = 0;
      drain();

      // Length boundary: MAX_DWORDS itself is legal, one more pulses len_err.
      lenerr_count = 0;
      send_frame(2049, 0, 2049);
      drain();
      chk("len_err_2049_count", 32'(lenerr_count), 32'd0);
      lenerr_count = 0;
      lenerr_at = 0;
      send_frame(2050, 0, 2050);
      drain();
      chk("len_err_2050_count", 32'(lenerr_count), 32'd1);
      chk("len_err_2050_at", 32'(lenerr_at), 32'd2050);
      $display("length frames done");

      // Asynchronous reset mid-frame.
      send_frame(5, 0, 2);
      @(posedge clk);
      #2;
      chk("pre_rst_out_val", 32'(out_val), 32'd1);
      rst_n = 1'b0;
      in_val = 1'b0;
      #1;
      chk("async_rst_out_val", 32'(out_val), 32'd0);
      chk("async_rst_out_data", out_data, 32'h0);
      chk("async_rst_in_ready", 32'(in_ready), 32'd1);
      exp_q.delete();
      frame_q.delete();
      prev_stall = 0;
      frame_done = 1;
      @(negedge clk);
      rst_n = 1'b1;
      send_frame(1, 0, 1);
      drain();
      $display("post-reset frame done");

`ifdef SATA_CRC_CORRUPT_EN
      corrupt_flag = 1;
      crc_corrupt = 1'b1;
      send_frame(3, 0, 3);
      drain();
      corrupt_flag = 0;
      crc_corrupt = 1'b0;
      $display("corrupt frame done");
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/sata_link_crc_tx.md
# sata_link_crc_tx

Transmit-side CRC stage of the SATA link layer. Placed directly upstream of the link scrambler. Accepts FIS payload dwords from the transport layer and computes the SATA CRC-32 over the frame. After the last payload dword it appends the CRC dword and forwards the complete stream to the scrambler through a registered valid/ready output.

## Interface
- DATA_BYTE_WIDTH, 4: dword width in bytes; only 4 is supported.
- MAX_DWORDS, 2049: maximum payload dwords per frame before `len_err` fires.
- CRC_INIT, 32'h52325032: CRC seed loaded at reset and at every frame start.

- clk  in  1  link clock; all state on its rising edge.
- rst_n  in  1  reset, asynchronous assert, active-low; deassertion must be synchronised to clk externally.
- in_data  in  32  payload dword.
- in_val  in  1  in_data valid.
- in_last  in  1  marks the final payload dword; qualified by in_val.
- in_ready  out  1  stage accepts in_data this cycle.
- out_data  out  32  payload or CRC dword, to the scrambler.
- out_val  out  1  out_data valid.
- out_crc  out  1  out_data is the CRC dword (the last dword of the frame).
- out_ready  in  1  downstream accepts out_data.
- len_err  out  1  one-cycle pulse when the payload exceeds MAX_DWORDS.
- crc_corrupt  in  1  present only with SATA_CRC_CORRUPT_EN.

## Operation
- Transfer rules:
  - An input transfer happens when in_val && in_ready.
  - An output transfer happens when out_val && out_ready.
- States:
  - DATA is the reset state. `in_ready = !out_val || out_ready`.
  - CRC: `in_ready = 0`.
- DATA, on an input transfer:
  - The output register loads in_data with out_val=1 and out_crc=0.
  - The CRC register is updated with in_data.
  - The dword counter increments.
  - If in_last=1, go to CRC.
- CRC, when `!out_val || out_ready`:
  - The output register loads the updated CRC with out_val=1 and out_crc=1.
  - The CRC register reloads CRC_INIT, the counter clears, and the state returns to DATA.
- CRC arithmetic:
  - Polynomial 0x04C11DB7, non-reflected, no final XOR.
  - Processes one 32-bit dword per update, bit 31 first, fully parallel (one dword per cycle).
- Output register hold rule: if out_val=1 and out_ready=0, out_data, out_val and out_crc hold unchanged.
- Output register drain rule: if it drains with no new load, out_val falls to 0 on the next cycle.
- Dword counter:
  - 12 bits, saturating at 4095.
  - len_err pulses for one cycle on the transfer that takes the count from MAX_DWORDS to MAX_DWORDS+1.
  - The frame continues unchanged after len_err.
- Single-dword frame: in_last on the first dword goes straight to CRC. The frame is 2 output dwords.
- Framing: no abort input. A frame ends only through in_last or reset.

## Timing
- Reset values: out_data=0, out_val=0, out_crc=0, in_ready=1, len_err=0. Internal: state=DATA, CRC=CRC_INIT, counter=0.
- Latency: input dword to out_data is 1 cycle.
- CRC dword appears on the cycle after the last payload dword is accepted, provided the output is free.
- Throughput:
  - 1 dword/cycle while out_ready=1.
  - Exactly one idle input cycle per frame (the CRC slot).
- Back-to-back frames: a new frame's first dword may be accepted in the same cycle the CRC dword transfers out.
- Reset mid-frame: all outputs go to their reset values immediately. The partial frame is discarded and the next accepted dword starts a new frame with CRC_INIT.
- in_last without in_val is ignored.
- in_data and in_last are sampled only on an input transfer.

## Configuration
- SATA_CRC_CORRUPT_EN defined:
  - The crc_corrupt port exists.
  - If crc_corrupt=1 on the cycle the CRC dword is loaded, the output CRC is bit-inverted (XOR 32'hFFFFFFFF).
  - Used for link error-path testing.
- Undefined: the port is absent and the CRC is always correct.

## Test plan
- Single frame, in_data 32'h00000027 then 32'h00EC0000 (last), out_ready=1:
  - out_data = 27, EC0000, then the reference-model CRC with out_crc=1.
  - in_ready=0 for exactly one cycle.
- Backpressure: out_ready toggles 1,0,0,1 during a 4-dword frame. No dword is lost or duplicated and out_data holds while stalled.
- Back-to-back frames of 1 and 3 dwords. The second CRC uses a fresh CRC_INIT and matches the model.
- 2050-dword frame with MAX_DWORDS=2049: len_err pulses exactly once, on dword 2050. The CRC is still correct.
- rst_n asserted after 2 dwords of a frame: out_val drops asynchronously. The next 1-dword frame's CRC matches the model.
- With SATA_CRC_CORRUPT_EN and crc_corrupt=1: the emitted CRC equals the model CRC ^ 32'hFFFFFFFF.
